// File: rtl/saw_period_meter_if.sv
// Sample bus into the sawtooth period meter and the
// measurement results it reports back.
interface saw_period_meter_if #(
    parameter int DATA_W = 12,
    parameter int CNT_W  = 20
);
    logic              sample_valid;
    logic [DATA_W-1:0] sample;
    logic [CNT_W-1:0]  period;
    logic              period_valid;
    logic [DATA_W-1:0] peak;
    logic [DATA_W-1:0] trough;
    logic              locked;
    logic              overflow;

    modport master (
        output sample_valid, sample,
        input  period, period_valid, peak, trough,
        input  locked, overflow
    );

    modport slave (
        input  sample_valid, sample,
        output period, period_valid, peak, trough,
        output locked, overflow
    );
endinterface

// File: rtl/saw_period_meter.sv
// Recovers sawtooth period from wrap-around drops, with
// per-period peak/trough, lock detection and overflow flag.
module saw_period_meter #(
    parameter int DATA_W      = 12,
    parameter int CNT_W       = 20,
    parameter int DROP_THRESH = 2048,
    parameter int LOCK_COUNT  = 4,
    parameter int TOL         = 2
) (
    input logic              clk,
    input logic              rst_n,
    input logic              clear,
    saw_period_meter_if.slave bus
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SEARCH  = 2'd1;
    localparam logic [1:0] MEASURE = 2'd2;

    localparam int MW  = $clog2(LOCK_COUNT + 1);
    localparam int DW1 = DATA_W + 1;

    localparam logic [MW-1:0]    LOCK_MAX = MW'(LOCK_COUNT);
    localparam logic [DW1-1:0]   THRESH   = DW1'(DROP_THRESH);
    localparam logic [CNT_W-1:0] TOL_C    = CNT_W'(TOL);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]        state;
    logic [DATA_W-1:0] prev;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] run_max;
    logic [DATA_W-1:0] run_min;
    logic [MW-1:0]     match_cnt;
    logic              has_ref;

    logic [CNT_W-1:0]  period_q;
    logic              pv_q;
    logic [DATA_W-1:0] peak_q;
    logic [DATA_W-1:0] trough_q;
    logic              locked_q;
    logic              ovf_q;

    logic [DW1-1:0]    drop;
    logic              wrap;
    logic [CNT_W-1:0]  pdiff;
    logic              match;
    logic [MW-1:0]     match_nxt;

    assign drop  = {1'b0, prev} - {1'b0, bus.sample};
    assign wrap  = bus.sample_valid && (state != IDLE) &&
                   (prev > bus.sample) && (drop >= THRESH);
    assign pdiff = (count >= period_q) ? count - period_q
                                       : period_q - count;
    // first period after SEARCH has no reference to match
    assign match = has_ref && (pdiff <= TOL_C);
    assign match_nxt = (match_cnt == LOCK_MAX) ? LOCK_MAX
                                               : match_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            prev      <= '0;
            count     <= '0;
            run_max   <= '0;
            run_min   <= '0;
            match_cnt <= '0;
            has_ref   <= 1'b0;
            period_q  <= '0;
            pv_q      <= 1'b0;
            peak_q    <= '0;
            trough_q  <= '0;
            locked_q  <= 1'b0;
            ovf_q     <= 1'b0;
        end else if (clear) begin
            state     <= IDLE;
            prev      <= '0;
            count     <= '0;
            run_max   <= '0;
            run_min   <= '0;
            match_cnt <= '0;
            has_ref   <= 1'b0;
            period_q  <= '0;
            pv_q      <= 1'b0;
            peak_q    <= '0;
            trough_q  <= '0;
            locked_q  <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            pv_q <= 1'b0;
            if (bus.sample_valid) begin
                prev <= bus.sample;
                case (state)
                    IDLE: state <= SEARCH;
                    SEARCH: begin
                        if (wrap) begin
                            count   <= CNT_ONE;
                            run_max <= bus.sample;
                            run_min <= bus.sample;
                            state   <= MEASURE;
                        end
                    end
                    MEASURE: begin
                        if (wrap) begin
                            period_q <= count;
                            peak_q   <= run_max;
                            trough_q <= run_min;
                            pv_q     <= 1'b1;
                            has_ref  <= 1'b1;
                            if (match) begin
                                match_cnt <= match_nxt;
                                locked_q  <= (match_nxt == LOCK_MAX);
                            end else begin
                                match_cnt <= '0;
                                locked_q  <= 1'b0;
                            end
                            count   <= CNT_ONE;
                            run_max <= bus.sample;
                            run_min <= bus.sample;
                        end else if (count == CNT_MAX) begin
                            ovf_q     <= 1'b1;
                            locked_q  <= 1'b0;
                            match_cnt <= '0;
                            has_ref   <= 1'b0;
                            state     <= SEARCH;
                        end else begin
                            count <= count + 1'b1;
                            if (bus.sample > run_max)
                                run_max <= bus.sample;
                            if (bus.sample < run_min)
                                run_min <= bus.sample;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.period       = period_q;
    assign bus.period_valid = pv_q;
    assign bus.peak         = peak_q;
    assign bus.trough       = trough_q;
    assign bus.locked       = locked_q;
    assign bus.overflow     = ovf_q;
endmodule

// File: tb/tb_saw_period_meter.sv
// Randomized bench: two meters (20-bit and 4-bit counters) fed
// the same samples, compared each cycle to a segment-based model.
module tb_saw_period_meter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;
    always #5 clk = ~clk;

    saw_period_meter_if #(.DATA_W(12), .CNT_W(20)) big_if ();
    saw_period_meter_if #(.DATA_W(12), .CNT_W(4))  small_if ();

    saw_period_meter #(
        .DATA_W(12), .CNT_W(20), .DROP_THRESH(2048),
        .LOCK_COUNT(4), .TOL(2)
    ) u_big (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .bus(big_if.slave)
    );

    saw_period_meter #(
        .DATA_W(12), .CNT_W(4), .DROP_THRESH(2048),
        .LOCK_COUNT(4), .TOL(2)
    ) u_small (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .bus(small_if.slave)
    );

    int checks = 0;
    int failures = 0;

    // model: current segment samples and recent emitted periods
    int m_prev[2];
    bit m_have[2];
    int seg[2][$];
    int hist[2][$];
    int e_period[2];
    int e_peak[2];
    int e_trough[2];
    bit e_pv[2];
    bit e_lock[2];
    bit e_ovf[2];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic int cap_of(input int m);
        return (m == 0) ? 1048575 : 15;
    endfunction

    function automatic void model_reset();
        for (int m = 0; m < 2; m++) begin
            m_prev[m] = 0;
            m_have[m] = 1'b0;
            seg[m].delete();
            hist[m].delete();
            e_period[m] = 0;
            e_peak[m] = 0;
            e_trough[m] = 0;
            e_pv[m] = 1'b0;
            e_lock[m] = 1'b0;
            e_ovf[m] = 1'b0;
        end
    endfunction

    function automatic void model_step(input int m, input bit v,
                                       input int s);
        bit wrap;
        int pk, tr, n;
        e_pv[m] = 1'b0;
        if (!v) return;
        wrap = m_have[m] && (m_prev[m] - s >= 2048);
        if (!m_have[m]) begin
            m_have[m] = 1'b1;
        end else if (seg[m].size() == 0) begin
            if (wrap) seg[m].push_back(s);
        end else if (wrap) begin
            pk = seg[m][0];
            tr = seg[m][0];
            for (int i = 1; i < seg[m].size(); i++) begin
                if (seg[m][i] > pk) pk = seg[m][i];
                if (seg[m][i] < tr) tr = seg[m][i];
            end
            e_period[m] = seg[m].size();
            e_peak[m] = pk;
            e_trough[m] = tr;
            e_pv[m] = 1'b1;
            hist[m].push_back(seg[m].size());
            while (hist[m].size() > 5) void'(hist[m].pop_front());
            n = 0;
            for (int i = hist[m].size() - 1; i > 0; i--) begin
                if (hist[m][i] - hist[m][i-1] <= 2 &&
                    hist[m][i-1] - hist[m][i] <= 2) n++;
                else break;
            end
            e_lock[m] = (n >= 4);
            seg[m].delete();
            seg[m].push_back(s);
        end else if (seg[m].size() == cap_of(m)) begin
            e_ovf[m] = 1'b1;
            e_lock[m] = 1'b0;
            hist[m].delete();
            seg[m].delete();
        end else begin
            seg[m].push_back(s);
        end
        m_prev[m] = s;
    endfunction

    task automatic check_all();
        chk("big.period", 32'(big_if.period), 32'(e_period[0]));
        chk("big.pv", 32'(big_if.period_valid), 32'(e_pv[0]));
        chk("big.peak", 32'(big_if.peak), 32'(e_peak[0]));
        chk("big.trough", 32'(big_if.trough), 32'(e_trough[0]));
        chk("big.locked", 32'(big_if.locked), 32'(e_lock[0]));
        chk("big.ovf", 32'(big_if.overflow), 32'(e_ovf[0]));
        chk("sml.period", 32'(small_if.period), 32'(e_period[1]));
        chk("sml.pv", 32'(small_if.period_valid), 32'(e_pv[1]));
        chk("sml.peak", 32'(small_if.peak), 32'(e_peak[1]));
        chk("sml.trough", 32'(small_if.trough), 32'(e_trough[1]));
        chk("sml.locked", 32'(small_if.locked), 32'(e_lock[1]));
        chk("sml.ovf", 32'(small_if.overflow), 32'(e_ovf[1]));
    endtask

    task automatic cyc(input bit v, input int s, input bit c);
        @(negedge clk);
        big_if.sample_valid = v;
        big_if.sample = 12'(s);
        small_if.sample_valid = v;
        small_if.sample = 12'(s);
        clear = c;
        @(posedge clk);
        if (c) begin
            model_reset();
        end else begin
            model_step(0, v, s);
            model_step(1, v, s);
        end
        #1 check_all();
    endtask

    // nper ramps of base+-jit samples; gap_pct% chance of idle cycles
    task automatic ramp(input int nper, input int base, input int jit,
                        input int gap_pct);
        int p, step;
        for (int r = 0; r < nper; r++) begin
            p = base + $urandom_range(0, 2 * jit) - jit;
            if (p < 3) p = 3;
            step = 4096 / p;
            for (int k = 0; k < p; k++) begin
                while ($urandom_range(0, 99) < gap_pct)
                    cyc(1'b0, $urandom_range(0, 4095), 1'b0);
                cyc(1'b1, k * step, 1'b0);
            end
        end
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        big_if.sample_valid = 1'b0;
        big_if.sample = '0;
        small_if.sample_valid = 1'b0;
        small_if.sample = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_all();
        @(negedge clk);
        rst_n = 1'b1;

        repeat (5) cyc(1'b1, 100, 1'b0);
        ramp(6, 16, 0, 0);
        ramp(6, 16, 0, 50);
        ramp(5, 16, 1, 0);
        ramp(1, 25, 0, 0);
        ramp(6, 16, 1, 0);

        cyc(1'b1, 3000, 1'b0);
        cyc(1'b1, 953, 1'b0);
        cyc(1'b1, 3000, 1'b0);
        cyc(1'b1, 952, 1'b0);
        cyc(1'b1, 0, 1'b0);
        cyc(1'b1, 4095, 1'b0);
        cyc(1'b1, 0, 1'b0);

        cyc(1'b1, 4000, 1'b0);
        cyc(1'b1, 0, 1'b1);

        ramp(3, 16, 0, 0);
        cyc(1'b1, 500, 1'b0);
        async_reset();

        cyc(1'b1, 4000, 1'b0);
        cyc(1'b1, 0, 1'b0);
        repeat (20) cyc(1'b1, 0, 1'b0);
        ramp(7, 10, 0, 0);
        cyc(1'b1, 4000, 1'b0);
        cyc(1'b1, 0, 1'b1);

        repeat (60) begin
            case ($urandom_range(0, 3))
                0: ramp($urandom_range(1, 8), $urandom_range(4, 30),
                        $urandom_range(0, 3), $urandom_range(0, 60));
                1: repeat (20)
                       cyc(1'($urandom_range(0, 1)),
                           $urandom_range(0, 4095),
                           1'($urandom_range(0, 99) < 3));
                2: cyc(1'b1, $urandom_range(0, 4095), 1'b1);
                default: repeat ($urandom_range(10, 25))
                       cyc(1'b1, 2000, 1'b0);
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
